// File: rtl/jof32_pkg.sv
// Shared encodings for the jof32 load/store path: access sizes, aligner FSM
// states, byte-enable patterns and small helpers on size/offset.
package jof32_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'd0,
    SZ_HALF     = 2'd1,
    SZ_WORD     = 2'd2,
    SZ_WORD_ALT = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LD1  = 2'd1,
    ST_LD2  = 2'd2,
    ST_ST2  = 2'd3
  } state_e;

  // Lane patterns are left-justified: bit 3 is the lane at byte offset 0.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b1000;
  localparam logic [3:0] BE_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [3:0] size_be(input logic [1:0] size);
    case (size)
      SZ_BYTE: return BE_BYTE;
      SZ_HALF: return BE_HALF;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic is_crossing(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return (off == 2'd3);
      default: return (off != 2'd0);
    endcase
  endfunction

  // Left shift that moves right-justified store data up to bits [31:..].
  function automatic logic [4:0] store_lshift(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 5'd24;
      SZ_HALF: return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Pulls the addressed bytes out of one or two big-endian RAM words and
// returns them right-justified, zero- or sign-extended.
module mem_lane_extract
  import jof32_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [DATA_W-1:0] word_hi,
  input  logic [DATA_W-1:0] word_lo,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ljust;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic s);
    return {{(DATA_W-8){s & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic s);
    return {{(DATA_W-16){s & h[15]}}, h};
  endfunction

  // Shifting the word pair left by the offset puts access byte 0 at [31:24].
  always_comb begin
    ljust = DATA_W'(({word_hi, word_lo} << {offset, 3'b000}) >> DATA_W);
    case (size)
      SZ_BYTE: rdata = ext_byte(ljust[DATA_W-1 -: 8], sext);
      SZ_HALF: rdata = ext_half(ljust[DATA_W-1 -: 16], sext);
      default: rdata = ljust;
    endcase
  end

endmodule

// File: rtl/mem_align_ctrl.sv
// Big-endian load/store aligner in front of a single-port word RAM; accesses
// that straddle a word boundary are split into two RAM cycles.
module mem_align_ctrl
  import jof32_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic [3:0]        ram_byteen,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [1:0]        off;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  req_t              live_req, sel;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              req_cross_q;
  logic [DATA_W-1:0] word_hi, ext_rdata;
  logic [DATA_W-1:0] st_ljust;
  logic [2*DATA_W-1:0] st_pair;
  logic [7:0]        be_pair;
  logic              unused_addr_hi;

  assign live_req.we    = req_we;
  assign live_req.size  = req_size;
  assign live_req.sext  = req_sext;
  assign live_req.off   = req_addr[1:0];
  assign live_req.idx   = req_addr[ADDR_W+1:2];
  assign live_req.wdata = req_wdata;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_cross_q = is_crossing(req_q.size, req_q.off);
  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

  // In LD2 the held first word supplies the leading bytes.
  assign word_hi = (state_q == ST_LD2) ? hold_q : ram_q;

  mem_lane_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .offset  (req_q.off),
    .size    (req_q.size),
    .sext    (req_q.sext),
    .word_hi (word_hi),
    .word_lo (ram_q),
    .rdata   (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      hold_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      hold_q      <= hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    hold_d      = hold_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = live_req;
          if (!req_we) begin
            state_d = ST_LD1;
          end else if (is_crossing(req_size, req_addr[1:0])) begin
            state_d = ST_ST2;
          end else begin
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_LD1: begin
        if (req_cross_q) begin
          hold_d  = ram_q;
          state_d = ST_LD2;
        end else begin
          rsp_rdata_d = ext_rdata;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_LD2: begin
        rsp_rdata_d = ext_rdata;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ST2: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Store lanes come from the live request in IDLE and the registered one later;
  // the upper half of each pair belongs to the first word, the lower to the second.
  always_comb begin
    sel         = (state_q == ST_IDLE) ? live_req : req_q;
    st_ljust    = sel.wdata << store_lshift(sel.size);
    st_pair     = {st_ljust, {DATA_W{1'b0}}} >> {sel.off, 3'b000};
    be_pair     = {size_be(sel.size), BE_NONE} >> sel.off;
    ram_address = sel.idx;
    ram_data    = '0;
    ram_byteen  = BE_NONE;
    ram_wren    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_we) begin
          ram_data   = st_pair[2*DATA_W-1:DATA_W];
          ram_byteen = be_pair[7:4];
          ram_wren   = 1'b1;
        end
      end
      ST_LD1: begin
        if (req_cross_q) begin
          ram_address = sel.idx + ADDR_W'(1);
        end
      end
      ST_LD2: begin
        ram_address = sel.idx;
      end
      ST_ST2: begin
        ram_address = sel.idx + ADDR_W'(1);
        ram_data    = st_pair[DATA_W-1:0];
        ram_byteen  = be_pair[3:0];
        ram_wren    = 1'b1;
      end
    endcase
    if (!rst_n) begin
      ram_wren   = 1'b0;
      ram_byteen = BE_NONE;
    end
  end

endmodule

// File: tb/tb_mem_align_ctrl.sv
// Directed bench for mem_align_ctrl with a behavioural single-port RAM model.
module tb_mem_align_ctrl;

  localparam int ADDR_W = 19;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_sext = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data;
  logic [3:0]        ram_byteen;
  logic              ram_wren;
  logic [31:0]       ram_q;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       wr_merged;
  logic              do_preload = 1'b1;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] wr_idx [0:63];
  logic [3:0]        wr_be  [0:63];

  int                n_checks = 0;
  int                n_errors = 0;
  int                last_wr0;
  logic [ADDR_W-1:0] addr_c1;
  logic [31:0]       held;
  int                wr_before;
  logic              seen_valid;

  mem_align_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_sext    (req_sext),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_byteen  (ram_byteen),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    wr_merged = mem[ram_address];
    for (int l = 0; l < 4; l++)
      if (ram_byteen[3-l]) wr_merged[31-8*l -: 8] = ram_data[31-8*l -: 8];
  end

  always @(posedge clk) begin
    ram_q <= mem[ram_address];
    if (do_preload) begin
      mem[0]         <= 32'h11223344;
      mem[1]         <= 32'h55667788;
      mem[2]         <= 32'h00000000;
      mem[3]         <= 32'hCAFEF00D;
      mem[4]         <= 32'h00000000;
      mem[19'h7FFFF] <= 32'hA1B2C3D4;
    end else if (ram_wren) begin
      mem[ram_address] <= wr_merged;
      if (wr_cnt < 64) begin
        wr_idx[wr_cnt] <= ram_address;
        wr_be[wr_cnt]  <= ram_byteen;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to rsp_valid; b2b skips the idle negedge.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input bit b2b);
    int  cyc;
    int  wr0;
    bit  seen;
    bit  early_ready;
    if (!b2b) @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
    wr0       = wr_cnt;
    last_wr0  = wr0;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid   = 1'b0;
    cyc         = 1;
    seen        = 1'b0;
    early_ready = 1'b0;
    while (!seen && cyc <= 8) begin
      if (cyc == 1) addr_c1 = ram_address;
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (req_ready) early_ready = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) cyc = 99;
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    if (exp_lat > 1) check({tag, "_busy"}, {31'd0, early_ready}, 32'd0);
    check({tag, "_nwr"}, 32'(wr_cnt - wr0), we ? 32'(exp_lat) : 32'd0);
    if (!we) check({tag, "_rdata"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    #1;
    check("rst_wren_gate", {31'd0, ram_wren}, 32'd0);
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (2) @(negedge clk);
    do_preload = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_byteen", {28'd0, ram_byteen}, 32'd0);

    do_req("ld_w0",     1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0, 2, 32'h11223344, 1'b0);
    do_req("ld_wx2",    1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0, 3, 32'h33445566, 1'b0);
    check("ld_wx2_idx2", 32'(addr_c1), 32'd1);
    do_req("ld_b7_s",   1'b0, 2'd0, 1'b1, 32'h0000_0007, 32'd0, 2, 32'hFFFFFF88, 1'b0);
    do_req("ld_b7_z",   1'b0, 2'd0, 1'b0, 32'h0000_0007, 32'd0, 2, 32'h00000088, 1'b1);
    do_req("ld_h1_s",   1'b0, 2'd1, 1'b1, 32'h0000_0001, 32'd0, 2, 32'h00002233, 1'b0);
    do_req("ld_hneg",   1'b0, 2'd1, 1'b1, 32'h001F_FFFC, 32'd0, 2, 32'hFFFFA1B2, 1'b1);
    do_req("ld_hx3",    1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'd0, 3, 32'h00004455, 1'b0);
    do_req("ld_wrap",   1'b0, 2'd2, 1'b0, 32'h001F_FFFE, 32'd0, 3, 32'hC3D41122, 1'b0);
    check("ld_wrap_idx2", 32'(addr_c1), 32'd0);

    held = rsp_rdata;
    seen_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("hold_rdata", rsp_rdata, held);
    check("hold_no_pulse", {31'd0, seen_valid}, 32'd0);

    do_req("st_w10",    1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0BADF00D, 1, 32'd0, 1'b0);
    check("st_w10_be", {28'd0, wr_be[last_wr0]}, 32'hF);
    do_req("rb_w10",    1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 2, 32'h0BADF00D, 1'b1);
    do_req("st_b11",    1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000005A, 1, 32'd0, 1'b0);
    check("st_b11_be", {28'd0, wr_be[last_wr0]}, 32'h4);
    do_req("rb_b11",    1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 2, 32'h0B5AF00D, 1'b1);

    do_req("st_hx3",    1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h0000ABCD, 2, 32'd0, 1'b0);
    check("st_hx3_idx0", 32'(wr_idx[last_wr0]), 32'd0);
    check("st_hx3_be0", {28'd0, wr_be[last_wr0]}, 32'h1);
    check("st_hx3_idx1", 32'(wr_idx[last_wr0+1]), 32'd1);
    check("st_hx3_be1", {28'd0, wr_be[last_wr0+1]}, 32'h8);
    do_req("rb_word0",  1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0, 2, 32'h112233AB, 1'b1);
    do_req("rb_word1",  1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'd0, 2, 32'hCD667788, 1'b1);
    do_req("ld_size3",  1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 2, 32'h112233AB, 1'b0);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_sext  = 1'b0;
    req_addr  = 32'h0000_0009;
    req_wdata = 32'hDEADBEEF;
    wr_before = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("st2_wren_pre", {31'd0, ram_wren}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("st2_wren_rst", {31'd0, ram_wren}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("st2_ready", {31'd0, req_ready}, 32'd1);
    check("st2_nwr", 32'(wr_cnt - wr_before), 32'd1);
    check("st2_word2", mem[2], 32'h00DEADBE);
    check("st2_word3", mem[3], 32'hCAFEF00D);
    seen_valid = rsp_valid;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("st2_no_rsp", {31'd0, seen_valid}, 32'd0);
    check("st2_rdata_rst", rsp_rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
